dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Round-robin arbiter that shares one synchronous-read data memory port among N_CORES matrix-multiplier cores.
- Each core's control unit raises a request with address, write flag and write data. The arbiter grants one core at a time, drives the memory port, captures read data, and pulses a per-core done.
- Sits between the cores' dm_wr/bus interfaces and the single data memory instance in the multi-core top level.

Parameters:
- N_CORES, 4, number of requesting cores (2..8)
- ADDR_W, 8, data memory address width
- DATA_W, 8, data word width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  N_CORES  per-core access request, level
- wr  in  N_CORES  per-core 1=write, 0=read; valid with req
- addr  in  N_CORES*ADDR_W  per-core address; core i at bits [i*ADDR_W +: ADDR_W]
- wdata  in  N_CORES*DATA_W  per-core write data, same packing
- gnt  out  N_CORES  one-hot owner of current transaction
- done  out  N_CORES  one-cycle completion pulse to owner
- rdata  out  DATA_W  last read word, shared by all cores
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_we  out  1  memory write enable
- mem_rdata  in  DATA_W  memory read data, valid one cycle after address
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst_n low, async): state=IDLE; gnt, done, rdata, mem_addr, mem_wdata, mem_we, busy all 0; last-granted pointer = N_CORES-1, so core 0 has first priority.
- States: IDLE, ACCESS, WAIT, RESP. All outputs are registered.
- Arbitration: scan req starting at (ptr+1) mod N_CORES, wrapping; the first set bit wins. On win:
  - ptr <= winner
  - gnt <= onehot(winner)
  - mem_addr, mem_wdata <= winner's addr, wdata
  - latch the winner's wr
- IDLE: if any req is set, arbitrate and go to ACCESS; else stay in IDLE.
- ACCESS (1 cycle): mem_addr/mem_wdata stable; mem_we = latched wr. Next state is WAIT.
- WAIT (1 cycle): mem_we=0. If the transaction is a read, rdata <= mem_rdata at the end of the cycle. Next state is RESP.
- RESP (1 cycle): done[owner]=1 and gnt held.
  - Arbitrate over req with the owner's bit masked.
  - On a winner, go directly to ACCESS with the new gnt/mem_addr.
  - Otherwise gnt <= 0 and go to IDLE.
- Latency: request seen in IDLE at edge T gives done high in cycle T+3. Back-to-back throughput is one access per 3 cycles.
- Requester contract:
  - Hold req, wr, addr and wdata stable until done.
  - Drop req in the cycle after done, unless another access is wanted; a req still high then is treated as a new request.
- Arbiter rules:
  - Inputs are sampled only at arbitration; later changes, including req dropping mid-transaction, are ignored and the transaction completes.
- rdata holds its value until the next read completes; writes do not change it.
- Fairness: any continuously requesting core is granted within N_CORES transactions.
- Simultaneous requests: the lowest index at or after ptr+1 (with wrap) wins.
- Reset mid-operation: all outputs clear immediately, including mem_we. A write interrupted during ACCESS is undefined in memory. No done is issued.

Test Plan:
- Single read: core1 req, wr=0, addr=0x12, memory[0x12]=0xA5 -> mem_addr=0x12 in ACCESS, mem_we=0, done[1] 3 cycles later, rdata=0xA5.
- Single write: core2 req, wr=1, addr=0x30, wdata=0x5C -> mem_we=1 exactly one cycle with mem_addr=0x30, mem_wdata=0x5C; done[2] pulse; rdata unchanged.
- All four request reads at once from reset -> grant order 0,1,2,3, each done 3 cycles apart, no IDLE gaps, busy continuously high.
- Round-robin wrap: after core2 is served, cores 0 and 3 request -> core3 granted before core0.
- Hog test: core0 holds req continuously while core1 requests -> grants alternate 0,1,0,1; core1 waits at most one transaction.
- Reset asserted during ACCESS of a write -> mem_we, gnt, busy drop to 0 asynchronously, no done pulse. After release, the pending req is arbitrated again with core 0 priority.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundle between N requesting cores and the shared synchronous-read data memory port.
// slave: the arbiter's view; master: the cores plus memory seen from outside.
interface dmem_arbiter_if #(
    parameter int N_CORES = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
);
    logic [N_CORES-1:0]        req;
    logic [N_CORES-1:0]        wr;
    logic [N_CORES*ADDR_W-1:0] addr;
    logic [N_CORES*DATA_W-1:0] wdata;
    logic [N_CORES-1:0]        gnt;
    logic [N_CORES-1:0]        done;
    logic [DATA_W-1:0]         rdata;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic                      mem_we;
    logic [DATA_W-1:0]         mem_rdata;
    logic                      busy;

    modport slave (
        input  req, wr, addr, wdata, mem_rdata,
        output gnt, done, rdata, mem_addr, mem_wdata, mem_we, busy
    );

    modport master (
        output req, wr, addr, wdata, mem_rdata,
        input  gnt, done, rdata, mem_addr, mem_wdata, mem_we, busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin share of one sync-read memory port; done pulses 3 cycles after the winning edge.
// Requesters hold req until done; one access per 3 cycles back to back, all outputs registered.
module dmem_arbiter #(
    parameter int N_CORES = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus
);
    localparam int PW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [N_CORES-1:0]  gnt_q, gnt_d;
    logic [N_CORES-1:0]  done_q, done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_we_q, mem_we_d;
    logic                wr_q, wr_d;
    logic                busy_q, busy_d;

    logic [N_CORES-1:0]  req_m;
    logic [PW-1:0]       idx;
    logic [PW-1:0]       win_idx;
    logic                win_vld;
    logic                arb_take;

    // The current owner is masked in RESP so a still-high req cannot win twice in a row.
    always_comb begin
        req_m   = bus.req;
        idx     = '0;
        win_idx = ptr_q;
        win_vld = 1'b0;
        if (state_q == RESP) begin
            req_m = bus.req & ~gnt_q;
        end
        for (int i = 1; i <= N_CORES; i++) begin
            idx = PW'((int'(ptr_q) + i) % N_CORES);
            if (!win_vld && req_m[idx]) begin
                win_vld = 1'b1;
                win_idx = idx;
            end
        end
    end

    assign arb_take = win_vld && ((state_q == IDLE) || (state_q == RESP));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = win_vld ? ACCESS : IDLE;
            ACCESS:  state_d = WAIT;
            WAIT:    state_d = RESP;
            RESP:    state_d = win_vld ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        done_d      = '0;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        wr_d        = wr_q;
        busy_d      = (state_d != IDLE);
        if (arb_take) begin
            ptr_d          = win_idx;
            gnt_d          = '0;
            gnt_d[win_idx] = 1'b1;
            mem_addr_d     = bus.addr[int'(win_idx)*ADDR_W +: ADDR_W];
            mem_wdata_d    = bus.wdata[int'(win_idx)*DATA_W +: DATA_W];
            wr_d           = bus.wr[win_idx];
            mem_we_d       = bus.wr[win_idx];
        end else if (state_q == RESP) begin
            gnt_d = '0;
        end
        // Memory returns data during WAIT for the address presented in ACCESS.
        if (state_q == WAIT) begin
            done_d = gnt_q;
            if (!wr_q) begin
                rdata_d = bus.mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= PW'(N_CORES - 1);
            gnt_q       <= '0;
            done_q      <= '0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            wr_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            wr_q        <= wr_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.busy      = busy_q;
endmodule
